tdm_rx: RTL and testbench

//  Deserialises one 8-slot TDM serial audio input into 8 parallel signed 24-bit samples.

---
 rtl/tdm_rx.sv | 126 ++++++++++++
 tb/tb_tdm_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_rx.sv
// TDM receiver: deserialises one NUM_CH-slot serial audio stream into parallel
// samples and publishes all channels together once per complete frame.
module tdm_rx #(
  parameter int NUM_CH    = 8,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bclk,
  input  logic                        fsync,
  input  logic                        sdata,
  output logic signed [DATA_BITS-1:0] audio_out [0:NUM_CH-1],
  output logic                        data_request,
  output logic                        locked,
  output logic                        frame_err
);
  localparam int F   = NUM_CH * SLOT_BITS;
  localparam int CW  = $clog2(F);
  localparam int SW  = $clog2(SLOT_BITS);
  localparam int CHW = CW - SW;
  localparam logic [CW-1:0]  LAST_BIT  = CW'(F - 1);
  localparam logic [SW-1:0]  LAST_IDX  = SW'(DATA_BITS - 1);
  localparam logic [CHW-1:0] LAST_SLOT = CHW'(NUM_CH - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        bit_cnt, cnt_nxt;
  logic                 err_nxt;
  logic [2:0]           bclk_sync;
  logic [1:0]           fsync_sync, sdata_sync;
  logic                 rise, fs, sd;
  logic [DATA_BITS-1:0] shreg, shift;
  logic [DATA_BITS-1:0] cap [NUM_CH];
  logic [CHW-1:0]       slot;
  logic [SW-1:0]        idx;

  // bclk gets a third stage so a rising edge is seen exactly once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync  <= '0;
      fsync_sync <= '0;
      sdata_sync <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[1:0], bclk};
      fsync_sync <= {fsync_sync[0], fsync};
      sdata_sync <= {sdata_sync[0], sdata};
    end
  end

  assign rise   = bclk_sync[1] & ~bclk_sync[2];
  assign fs     = fsync_sync[1];
  assign sd     = sdata_sync[1];
  assign slot   = bit_cnt[CW-1:SW];
  assign idx    = bit_cnt[SW-1:0];
  assign shift  = {shreg[DATA_BITS-2:0], sd};
  assign locked = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // fsync on a rise marks the following rise as bit 0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    err_nxt   = 1'b0;
    if (rise) begin
      case (state)
        HUNT: begin
          if (fs) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (fs) begin
            cnt_nxt = '0;
            err_nxt = (bit_cnt != LAST_BIT);
          end else if (bit_cnt == LAST_BIT) begin
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end else begin
            cnt_nxt = bit_cnt + CW'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // An early fsync restarts bit_cnt, so a partial frame never reaches the last slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      data_request <= 1'b0;
      frame_err    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cap[c]       <= '0;
        audio_out[c] <= '0;
      end
    end else begin
      data_request <= 1'b0;
      frame_err    <= err_nxt;
      if (rise && state == RUN && idx <= LAST_IDX) begin
        shreg <= shift;
        if (idx == LAST_IDX) begin
          cap[slot] <= shift;
          if (slot == LAST_SLOT) begin
            for (int c = 0; c < NUM_CH - 1; c++) audio_out[c] <= cap[c];
            audio_out[NUM_CH-1] <= shift;
            data_request        <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_rx.sv
// Directed bench for tdm_rx: drives a bit-level TDM stream and checks samples,
// pulses and lock state against hand-computed expectations.
module tb_tdm_rx;
  localparam int NCH = 8;
  localparam int DB  = 24;
  localparam int F   = 256;

  logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, fsync = 1'b0, sdata = 1'b0;
  logic signed [DB-1:0] audio_out [0:NCH-1];
  logic data_request, locked, frame_err;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, dreq_cnt = 0, ferr_cnt = 0, rst_pulse = 0, wide = 0, last_dreq = 0;
  logic dr_q = 1'b0, fe_q = 1'b0;
  logic [DB-1:0] pat [NCH];
  int jp = 0;
  bit jit = 1'b0;

  always #5 clk = ~clk;

  tdm_rx dut (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .fsync(fsync), .sdata(sdata),
    .audio_out(audio_out), .data_request(data_request), .locked(locked),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (data_request) begin
      dreq_cnt  <= dreq_cnt + 1;
      last_dreq <= cyc;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (!rst_n && (data_request || frame_err)) rst_pulse <= rst_pulse + 1;
    if ((data_request && dr_q) || (frame_err && fe_q)) wide <= wide + 1;
    dr_q <= data_request;
    fe_q <= frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_audio(input string tag);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s ch%0d", tag, c), 32'($unsigned(audio_out[c])), 32'(pat[c]));
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // called on a negedge; low phase lo clk, then high phase hi clk
  task automatic send_bit(input logic fs, input logic d, input int lo, input int hi);
    bclk = 1'b0; fsync = fs; sdata = d;
    repeat (lo) @(negedge clk);
    bclk = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic do_reset();
    bclk = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("rst audio ch%0d", c), 32'($unsigned(audio_out[c])), 32'd0);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst pulses", 32'(data_request | frame_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic fs_end, input int early, input int rst_at);
    for (int b = 0; b < F; b++) begin
      int s = b / 32;
      int i = b % 32;
      logic d, fs;
      int lo, hi, j;
      d  = (i < DB) ? pat[s][DB-1-i] : 1'b1;
      fs = (b == F-1) ? fs_end : (b == early);
      lo = 2; hi = 2;
      if (jit) begin
        j  = int'($urandom_range(2)) - 1;
        lo = 3 + j - jp;
        hi = 1;
        jp = j;
      end
      if (b == rst_at) do_reset();
      send_bit(fs, d, lo, hi);
      if (b == early) return;
    end
  endtask

  task automatic set_a();
    for (int s = 0; s < NCH - 1; s++) pat[s] = 24'(24'h111111 * (s + 1));
    pat[NCH-1] = 24'h800001;
  endtask

  task automatic set_b();
    for (int s = 0; s < NCH; s++) pat[s] = 24'h0F0F00 + 24'(s);
  endtask

  initial begin
    int base, fbase, prev, gap;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset dreq", 32'(data_request), 32'd0);
    chk("reset ferr", 32'(frame_err), 32'd0);
    chk("reset audio0", 32'($unsigned(audio_out[0])), 32'd0);
    chk("reset audio7", 32'($unsigned(audio_out[7])), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // hunting: data ignored until fsync
    repeat (5) send_bit(1'b0, 1'b1, 2, 2);
    settle();
    chk("hunt locked", 32'(locked), 32'd0);
    send_bit(1'b1, 1'b0, 2, 2);
    settle();
    chk("lock after fsync", 32'(locked), 32'd1);

    // clean frames
    set_a();
    base = dreq_cnt;
    send_frame(1'b1, -1, -1);
    chk_audio("clean1");
    chk("clean1 dreq", 32'(dreq_cnt), 32'(base + 1));
    send_frame(1'b1, -1, -1);
    chk_audio("clean2");
    chk("clean2 dreq", 32'(dreq_cnt), 32'(base + 2));
    chk("clean ferr", 32'(ferr_cnt), 32'd0);
    chk("clean locked", 32'(locked), 32'd1);

    // early fsync at bit 100
    base = dreq_cnt; fbase = ferr_cnt;
    set_b();
    send_frame(1'b1, 100, -1);
    settle();
    chk("early ferr", 32'(ferr_cnt), 32'(fbase + 1));
    chk("early no dreq", 32'(dreq_cnt), 32'(base));
    chk("early locked", 32'(locked), 32'd1);
    send_frame(1'b1, -1, -1);
    chk_audio("after early");
    chk("after early dreq", 32'(dreq_cnt), 32'(base + 1));

    // missing fsync at bit 255
    set_a();
    base = dreq_cnt; fbase = ferr_cnt;
    send_frame(1'b0, -1, -1);
    settle();
    chk_audio("missing delivered");
    chk("missing dreq", 32'(dreq_cnt), 32'(base + 1));
    chk("missing ferr", 32'(ferr_cnt), 32'(fbase + 1));
    chk("missing locked", 32'(locked), 32'd0);
    repeat (3) send_bit(1'b0, 1'b0, 2, 2);
    send_bit(1'b1, 1'b1, 2, 2);
    set_b();
    send_frame(1'b1, -1, -1);
    chk_audio("relock");
    chk("relock dreq", 32'(dreq_cnt), 32'(base + 2));
    chk("relock locked", 32'(locked), 32'd1);

    // reset pulse at bit 130; fsync at bit 255 of that frame relocks
    set_a();
    base = dreq_cnt;
    send_frame(1'b1, -1, 130);
    settle();
    chk("rst frame no dreq", 32'(dreq_cnt), 32'(base));
    chk("rst frame audio0", 32'($unsigned(audio_out[0])), 32'd0);
    chk("rst relocked", 32'(locked), 32'd1);
    set_b();
    send_frame(1'b1, -1, -1);
    chk_audio("post rst");
    chk("post rst dreq", 32'(dreq_cnt), 32'(base + 1));

    // jittered bclk, random data, 50 frames
    jit = 1'b1; jp = 0; prev = 0;
    base = dreq_cnt;
    for (int k = 0; k < 50; k++) begin
      for (int c = 0; c < NCH; c++) pat[c] = 24'($urandom);
      send_frame(1'b1, -1, -1);
      chk_audio($sformatf("jit f%0d", k));
      chk("jit dreq", 32'(dreq_cnt), 32'(base + k + 1));
      if (k > 0) begin
        gap = last_dreq - prev;
        chk($sformatf("jit gap %0d", gap), 32'(gap >= 1022 && gap <= 1026), 32'd1);
      end
      prev = last_dreq;
    end
    jit = 1'b0;

    chk("pulse width", 32'(wide), 32'd0);
    chk("pulses in reset", 32'(rst_pulse), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
